adc_sample_scheduler: RTL and testbench

- Sequences one LTC2320 octal-ADC driver instance: decides when conversions start, runs the trigger/done handshake, and captures the 8 channels at the end of each conversion.
- Start events come from a free-running period timer or from an external PWM-carrier sync pulse.
- Optionally averages 2^avg_shift conversions before presenting one result set to the register/bus layer.
- Sits between the AXI register block and the ADC driver.

---
 rtl/adc_sample_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: start-event generation, trigger/done handshake
// and per-channel averaging for one LTC2320 octal-ADC driver.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               0 stops new start events, timer held at 0
//   mode                 0 = period timer, 1 = sync_in rising edge
//   period_cycles        timer period in clk cycles (values < 2 act as 2)
//   sync_in              carrier sync, a rising edge is a start event
//   avg_shift            average 2^avg_shift conversions per result
//   adc_trigger          trigger to driver, held until adc_done falls
//   adc_done             driver idle flag (low while converting)
//   adc_data_valid       driver data strobe, observed by assertions only
//   adc_data             8 x 15-bit samples, channel 1 in [14:0]
//   out_data, out_valid  averaged result and its one-cycle update pulse
//   overrun_count        saturating count of dropped start events
//   timeout_err          sticky handshake timeout flag
//   err_clear            clears timeout_err and overrun_count
module adc_sample_scheduler #(
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] period_cycles,
    input  logic                sync_in,
    input  logic [1:0]          avg_shift,
    output logic                adc_trigger,
    input  logic                adc_done,
    input  logic                adc_data_valid,
    input  logic [119:0]        adc_data,
    output logic [119:0]        out_data,
    output logic                out_valid,
    output logic [15:0]         overrun_count,
    output logic                timeout_err,
    input  logic                err_clear
);

    localparam int NCH  = 8;
    localparam int CW   = 15;
    localparam int AW   = 18;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_CAPTURE
    } state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_W-1:0]    timer_q, timer_d;
    logic [PERIOD_W-1:0]    per_eff, per_last;
    logic                   sync_q, sync_prev_q;
    logic                   tmr_evt, sync_evt, evt;
    logic                   pending_q, pending_d, consume;
    logic [15:0]            ovr_q, ovr_d;
    logic                   terr_q, terr_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic                   to_expired, to_hit, cap;
    logic [NCH-1:0][AW-1:0] acc_q, acc_d, sum;
    logic [3:0]             cnt_q, cnt_d, cnt_inc;
    logic [1:0]             shift_q, shift_d, shift_eff;
    logic                   win_done;
    logic [NCH*CW-1:0]      out_q, out_d;
    logic                   ov_q, ov_d;

    // ---------------- start events ----------------
    always_comb begin
        per_eff  = (period_cycles < PERIOD_W'(2)) ? PERIOD_W'(2)
                                                  : period_cycles;
        per_last = per_eff - PERIOD_W'(1);
        timer_d  = '0;
        tmr_evt  = 1'b0;
        if (enable && !mode) begin
            // >= so a period shrunk below the current count still wraps
            if (timer_q >= per_last) begin
                tmr_evt = 1'b1;
            end else begin
                timer_d = timer_q + PERIOD_W'(1);
            end
        end
        sync_evt = sync_q & ~sync_prev_q;
        evt      = enable & (mode ? sync_evt : tmr_evt);
    end

    // ---------------- handshake FSM ----------------
    assign to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        adc_trigger = 1'b0;
        consume     = 1'b0;
        to_d        = to_q;
        to_hit      = 1'b0;
        cap         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    consume     = 1'b1;
                    adc_trigger = 1'b1;
                    to_d        = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // driver ignores trigger during its dead time: hold it
                adc_trigger = 1'b1;
                to_d        = to_q + TO_W'(1);
                if (!adc_done) begin
                    to_d    = '0;
                    state_d = S_BUSY;
                end else if (to_expired) begin
                    to_hit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                to_d = to_q + TO_W'(1);
                if (adc_done) begin
                    state_d = S_CAPTURE;
                end else if (to_expired) begin
                    to_hit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                cap     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- pending / error flags ----------------
    always_comb begin
        pending_d = pending_q;
        if (consume) begin
            pending_d = 1'b0;
        end
        // an event on the consume cycle re-arms rather than overruns
        if (evt) begin
            pending_d = 1'b1;
        end
        ovr_d = ovr_q;
        if (err_clear) begin
            ovr_d = '0;
        end else if (evt && pending_q && !consume && ovr_q != 16'hFFFF) begin
            ovr_d = ovr_q + 16'd1;
        end
        terr_d = terr_q;
        if (err_clear) begin
            terr_d = 1'b0;
        end
        if (to_hit) begin
            terr_d = 1'b1;
        end
    end

    // ---------------- averaging ----------------
    // shift is latched on the first capture of a window so a mid-window
    // change of avg_shift only affects the next window
    assign shift_eff = (cnt_q == 4'd0) ? avg_shift : shift_q;
    assign cnt_inc   = cnt_q + 4'd1;
    assign win_done  = (cnt_inc == (4'd1 << shift_eff));

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            sum[ch] = acc_q[ch] + AW'(adc_data[ch*CW +: CW]);
        end
        if (cap) begin
            shift_d = shift_eff;
            if (win_done) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    out_d[ch*CW +: CW] = CW'(sum[ch] >> shift_eff);
                end
                acc_d = '0;
                cnt_d = '0;
                ov_d  = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end else if (to_hit) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            ovr_q       <= '0;
            terr_q      <= 1'b0;
            to_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sync_q      <= sync_in;
            sync_prev_q <= sync_q;
            pending_q   <= pending_d;
            ovr_q       <= ovr_d;
            terr_q      <= terr_d;
            to_q        <= to_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            ov_q        <= ov_d;
        end
    end

    assign out_data      = out_q;
    assign out_valid     = ov_q;
    assign overrun_count = ovr_q;
    assign timeout_err   = terr_q;

    // ---------------- assertions ----------------
    a_no_trig_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == S_BUSY) |-> !adc_trigger
    );

    a_dv_known: assert property (
        @(posedge clk) disable iff (!rst_n)
        !$isunknown(adc_data_valid)
    );

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed bench for adc_sample_scheduler
// with a behavioural LTC2320 driver model.
module tb_adc_sample_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         mode = 1'b1;
    logic [15:0]  period_cycles = 16'd1000;
    logic         sync_in = 1'b0;
    logic [1:0]   avg_shift = 2'd0;
    logic         adc_trigger;
    logic         adc_done;
    logic         adc_data_valid;
    logic [119:0] adc_data;
    logic [119:0] out_data;
    logic         out_valid;
    logic [15:0]  overrun_count;
    logic         timeout_err;
    logic         err_clear = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    adc_sample_scheduler #(
        .PERIOD_W      (16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode          (mode),
        .period_cycles (period_cycles),
        .sync_in       (sync_in),
        .avg_shift     (avg_shift),
        .adc_trigger   (adc_trigger),
        .adc_done      (adc_done),
        .adc_data_valid(adc_data_valid),
        .adc_data      (adc_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .err_clear     (err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver model ----------------
    int          conv_len  = 20;
    int          dead_cfg  = 1;
    bit          hang_req  = 1'b0;
    bit          hang_busy = 1'b0;
    logic [14:0] next_val  = '0;
    int          wait_cnt  = 0;
    int          busy_cnt  = 0;
    int          conv_cnt  = 0;

    function automatic logic [119:0] pack(input logic [14:0] v);
        logic [119:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*15 +: 15] = v + 15'(k * 100);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_done       <= 1'b1;
            adc_data_valid <= 1'b0;
            adc_data       <= '0;
            wait_cnt       <= 0;
            busy_cnt       <= 0;
        end else begin
            adc_data_valid <= 1'b0;
            if (adc_done) begin
                if (adc_trigger && !hang_req) begin
                    if (wait_cnt >= dead_cfg - 1) begin
                        adc_done <= 1'b0;
                        wait_cnt <= 0;
                        busy_cnt <= 0;
                    end else begin
                        wait_cnt <= wait_cnt + 1;
                    end
                end else begin
                    wait_cnt <= 0;
                end
            end else if (!hang_busy) begin
                if (busy_cnt >= conv_len - 1) begin
                    adc_done       <= 1'b1;
                    adc_data       <= pack(next_val);
                    adc_data_valid <= 1'b1;
                    conv_cnt       <= conv_cnt + 1;
                end else begin
                    busy_cnt <= busy_cnt + 1;
                end
            end
        end
    end

    // ---------------- out_valid monitor ----------------
    int           ov_cnt = 0;
    logic [119:0] ov_data = '0;

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cnt  = ov_cnt + 1;
            ov_data = out_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [119:0] got,
                         input logic [119:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        tick(1);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
    endtask

    task automatic do_conv();
        int c0;
        int k;
        c0 = conv_cnt;
        k  = 0;
        pulse();
        while (conv_cnt == c0 && k < 1000) begin
            tick(1);
            k++;
        end
        if (k >= 1000) bound_fail("conv_wait");
        tick(4);
    endtask

    // sync pulse, then latency to trigger, trigger-high length, and
    // how many trigger-high cycles saw adc_done low
    task automatic meas_trig(output int lat, output int hi, output int lowc);
        lat  = 0;
        hi   = 0;
        lowc = 0;
        tick(1);
        sync_in = 1'b1;
        @(negedge clk);
        while (!adc_trigger && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        sync_in = 1'b0;
        while (adc_trigger && hi < 3000) begin
            hi++;
            if (!adc_done) lowc++;
            @(negedge clk);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]       sh;
        logic [7:0][14:0] v;
        logic [14:0]      ech1;
    } vec_t;

    typedef struct {
        logic [15:0] per;
        int          lat;
    } pvec_t;

    vec_t  vecs[7];
    pvec_t pvecs[4];

    initial begin
        int lat, hi, lowc, base, c0, p, nconv;
        bit last, rise;
        logic [119:0] e;

        vecs[0] = '{2'd0, {{7{15'd0}}, 15'h1234}, 15'h1234};
        vecs[1] = '{2'd2, {{4{15'd0}}, 15'd14, 15'd12, 15'd11, 15'd10},
                    15'd11};
        vecs[2] = '{2'd1, {{6{15'd0}}, 15'd4, 15'd3}, 15'd3};
        vecs[3] = '{2'd1, {{6{15'd0}}, 15'h7fff, 15'h7fff}, 15'h7fff};
        vecs[4] = '{2'd3, {8{15'h7fff}}, 15'h7fff};
        vecs[5] = '{2'd3, {15'd8, 15'd7, 15'd6, 15'd5,
                           15'd4, 15'd3, 15'd2, 15'd1}, 15'd4};
        vecs[6] = '{2'd0, {8{15'd0}}, 15'd0};

        pvecs[0] = '{16'd0, 2};
        pvecs[1] = '{16'd1, 2};
        pvecs[2] = '{16'd2, 2};
        pvecs[3] = '{16'd3, 3};

        // reset values
        #12;
        check("rst_trigger", 120'(adc_trigger), 120'(0));
        check("rst_out_valid", 120'(out_valid), 120'(0));
        check("rst_out_data", out_data, 120'(0));
        check("rst_overrun", 120'(overrun_count), 120'(0));
        check("rst_timeout", 120'(timeout_err), 120'(0));
        tick(1);
        rst_n  = 1'b1;
        enable = 1'b1;
        mode   = 1'b1;
        tick(3);

        // table-driven averaging windows, sync mode
        for (int i = 0; i < 7; i++) begin
            nconv     = 1 << vecs[i].sh;
            base      = ov_cnt;
            avg_shift = vecs[i].sh;
            for (int j = 0; j < nconv; j++) begin
                if (j == nconv - 1) begin
                    check($sformatf("vec%0d_early", i), 120'(ov_cnt),
                          120'(base));
                end
                next_val = vecs[i].v[j];
                do_conv();
            end
            e = '0;
            for (int k = 0; k < 8; k++) begin
                int s;
                s = 0;
                for (int j = 0; j < nconv; j++) begin
                    s += (int'(vecs[i].v[j]) + k * 100) % 32768;
                end
                e[k*15 +: 15] = 15'(s >> vecs[i].sh);
            end
            check($sformatf("vec%0d_cnt", i), 120'(ov_cnt), 120'(base + 1));
            check($sformatf("vec%0d_ch1", i), 120'(ov_data[14:0]),
                  120'(vecs[i].ech1));
            check($sformatf("vec%0d_all", i), ov_data, e);
        end

        // avg_shift change mid-window applies to the next window
        avg_shift = 2'd1;
        base      = ov_cnt;
        next_val  = 15'd20;
        do_conv();
        avg_shift = 2'd0;
        next_val  = 15'd40;
        do_conv();
        check("shiftchg_cnt1", 120'(ov_cnt), 120'(base + 1));
        check("shiftchg_ch1a", 120'(ov_data[14:0]), 120'(30));
        next_val = 15'd7;
        do_conv();
        check("shiftchg_cnt2", 120'(ov_cnt), 120'(base + 2));
        check("shiftchg_ch1b", 120'(ov_data[14:0]), 120'(7));

        // overrun: three sync edges within one conversion
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        conv_len  = 60;
        c0        = conv_cnt;
        pulse();
        tick(3);
        pulse();
        tick(3);
        pulse();
        tick(300);
        check("ovr_convs", 120'(conv_cnt), 120'(c0 + 2));
        check("ovr_count", 120'(overrun_count), 120'(1));
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ovr_clear", 120'(overrun_count), 120'(0));
        conv_len = 20;

        // trigger held across 200-cycle driver dead time
        dead_cfg = 200;
        meas_trig(lat, hi, lowc);
        check("sync_latency", 120'(lat), 120'(2));
        check("hold_len", 120'(hi), 120'(201));
        check("hold_lowcyc", 120'(lowc), 120'(1));
        tick(60);
        dead_cfg = 1;

        // timeout in S_REQ
        hang_req = 1'b1;
        meas_trig(lat, hi, lowc);
        check("to_req_len", 120'(hi), 120'(1025));
        check("to_req_err", 120'(timeout_err), 120'(1));
        hang_req = 1'b0;
        tick(5);
        check("to_req_trig", 120'(adc_trigger), 120'(0));
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("to_clear", 120'(timeout_err), 120'(0));

        // timeout in S_BUSY discards the partial window
        avg_shift = 2'd1;
        next_val  = 15'd100;
        do_conv();
        base      = ov_cnt;
        hang_busy = 1'b1;
        pulse();
        tick(1100);
        check("to_busy_err", 120'(timeout_err), 120'(1));
        check("to_busy_trig", 120'(adc_trigger), 120'(0));
        hang_busy = 1'b0;
        tick(30);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        next_val = 15'd200;
        do_conv();
        check("to_busy_noout", 120'(ov_cnt), 120'(base));
        next_val = 15'd300;
        do_conv();
        check("to_busy_cnt", 120'(ov_cnt), 120'(base + 1));
        check("to_busy_ch1", 120'(ov_data[14:0]), 120'(250));

        // reset during S_BUSY
        next_val = 15'd1000;
        do_conv();
        conv_len = 60;
        pulse();
        p = 0;
        while (adc_done && p < 50) begin
            tick(1);
            p++;
        end
        if (p >= 50) bound_fail("rst_busy_wait");
        tick(3);
        pulse();
        tick(3);
        pulse();
        tick(2);
        check("pre_rst_ovr", 120'(overrun_count), 120'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_trigger", 120'(adc_trigger), 120'(0));
        check("arst_out_valid", 120'(out_valid), 120'(0));
        check("arst_out_data", out_data, 120'(0));
        check("arst_overrun", 120'(overrun_count), 120'(0));
        check("arst_timeout", 120'(timeout_err), 120'(0));
        tick(3);
        rst_n    = 1'b1;
        conv_len = 20;
        c0       = conv_cnt;
        tick(50);
        check("arst_no_spur", 120'(conv_cnt), 120'(c0));
        base     = ov_cnt;
        next_val = 15'd40;
        do_conv();
        check("arst_noout", 120'(ov_cnt), 120'(base));
        next_val = 15'd60;
        do_conv();
        check("arst_cnt", 120'(ov_cnt), 120'(base + 1));
        check("arst_ch1", 120'(ov_data[14:0]), 120'(50));

        // periodic mode, period 1000
        avg_shift     = 2'd0;
        next_val      = 15'h1234;
        period_cycles = 16'd1000;
        base          = ov_cnt;
        mode          = 1'b0;
        p             = 0;
        @(negedge clk);
        while (!adc_trigger && p < 3000) begin
            p++;
            @(negedge clk);
        end
        check("per_first", 120'(p), 120'(1000));
        for (int r = 0; r < 2; r++) begin
            p    = 0;
            last = 1'b1;
            do begin
                @(negedge clk);
                p++;
                rise = adc_trigger && !last;
                last = adc_trigger;
            end while (!rise && p < 3000);
            check($sformatf("per_interval%0d", r), 120'(p), 120'(1000));
        end
        tick(40);
        check("per_outcnt", 120'(ov_cnt), 120'(base + 3));
        check("per_ch1", 120'(ov_data[14:0]), 120'(16'h1234));
        check("per_overrun", 120'(overrun_count), 120'(0));

        // small periods clamp to 2
        for (int i = 0; i < 4; i++) begin
            enable = 1'b0;
            tick(100);
            period_cycles = pvecs[i].per;
            enable        = 1'b1;
            p             = 0;
            @(negedge clk);
            while (!adc_trigger && p < 50) begin
                p++;
                @(negedge clk);
            end
            check($sformatf("per%0d_first", pvecs[i].per), 120'(p),
                  120'(pvecs[i].lat));
        end
        enable = 1'b0;
        tick(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
